// File: rtl/lock_sequencer_if.sv
// Keypad-side and actuator-side signals of the serial-code lock controller.
// Optional relock input is present only when LOCK_MANUAL_RELOCK_EN is defined.
interface lock_sequencer_if #(
    parameter int CODE_LEN = 4,
    parameter int MAX_FAIL = 3
);
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic              A;
    logic              a_valid;
    logic              abort;
`ifdef LOCK_MANUAL_RELOCK_EN
    logic              relock;
`endif
    logic              unlock;
    logic              locked_out;
    logic              busy;
    logic [FAIL_W-1:0] fail_cnt;
    logic [CNT_W-1:0]  bit_cnt;

    modport master (
        output A, a_valid, abort,
`ifdef LOCK_MANUAL_RELOCK_EN
        output relock,
`endif
        input  unlock, locked_out, busy, fail_cnt, bit_cnt
    );

    modport slave (
        input  A, a_valid, abort,
`ifdef LOCK_MANUAL_RELOCK_EN
        input  relock,
`endif
        output unlock, locked_out, busy, fail_cnt, bit_cnt
    );
endinterface

// File: rtl/lock_sequencer.sv
// Serial-code door lock sequencer: collects attempts, pulses unlock on match, times lockout.
// Optional manual relock is enabled by defining LOCK_MANUAL_RELOCK_EN.
module lock_sequencer #(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b0110,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  UNLOCK_CYCLES  = 4,
    parameter int                  LOCKOUT_CYCLES = 8
) (
    input logic              clk,
    input logic              reset,
    lock_sequencer_if.slave  bus
);
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  UNL_INIT   = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_INIT  = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CODE_LEN-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [FAIL_W-1:0] fail_cnt, fail_cnt_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic              unlock_q, unlock_nxt;
    logic              locked_q, locked_nxt;
    logic              busy_q, busy_nxt;

    // Saturating failure increment; the counter never wraps past the limit.
    function automatic logic [FAIL_W-1:0] fail_step(input logic [FAIL_W-1:0] cnt);
        if (cnt >= FAIL_LIMIT)
            return FAIL_LIMIT;
        return cnt + FAIL_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= COLLECT;
            sreg     <= '0;
            bit_cnt  <= '0;
            fail_cnt <= '0;
            timer    <= '0;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            fail_cnt <= fail_cnt_nxt;
            timer    <= timer_nxt;
            unlock_q <= unlock_nxt;
            locked_q <= locked_nxt;
            busy_q   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        bit_cnt_nxt  = bit_cnt;
        fail_cnt_nxt = fail_cnt;
        timer_nxt    = timer;
        unlock_nxt   = unlock_q;
        locked_nxt   = locked_q;

        case (state)
            COLLECT: begin
                if (bus.abort) begin
                    sreg_nxt    = '0;
                    bit_cnt_nxt = '0;
                end else if (bus.a_valid) begin
                    // First received bit ends up in the MSB once the attempt is complete.
                    sreg_nxt    = (sreg << 1) | CODE_LEN'(bus.A);
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT)
                        state_nxt = CHECK;
                end
            end

            CHECK: begin
                sreg_nxt    = '0;
                bit_cnt_nxt = '0;
                if (sreg == CODE) begin
                    fail_cnt_nxt = '0;
                    timer_nxt    = UNL_INIT;
                    unlock_nxt   = 1'b1;
                    state_nxt    = UNLOCKED;
                end else if (fail_step(fail_cnt) >= FAIL_LIMIT) begin
                    fail_cnt_nxt = FAIL_LIMIT;
                    timer_nxt    = LOCK_INIT;
                    locked_nxt   = 1'b1;
                    state_nxt    = LOCKOUT;
                end else begin
                    fail_cnt_nxt = fail_step(fail_cnt);
                    state_nxt    = COLLECT;
                end
            end

            UNLOCKED: begin
`ifdef LOCK_MANUAL_RELOCK_EN
                if (bus.relock) begin
                    timer_nxt  = '0;
                    unlock_nxt = 1'b0;
                    state_nxt  = COLLECT;
                end else
`endif
                if (timer == '0) begin
                    unlock_nxt = 1'b0;
                    state_nxt  = COLLECT;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            LOCKOUT: begin
                if (timer == '0) begin
                    locked_nxt   = 1'b0;
                    fail_cnt_nxt = '0;
                    state_nxt    = COLLECT;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end

            default: state_nxt = COLLECT;
        endcase

        busy_nxt = (state_nxt != COLLECT);
    end

    assign bus.unlock     = unlock_q;
    assign bus.locked_out = locked_q;
    assign bus.busy       = busy_q;
    assign bus.fail_cnt   = fail_cnt;
    assign bus.bit_cnt    = bit_cnt;
endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Controller that sequences a serial-code door lock.
- Collects fixed-length code attempts from a serial bit input and compares each complete attempt against a programmed code.
- Drives a timed unlock pulse on a match.
- Counts consecutive failed attempts and enforces a timed lockout once the failure limit is reached.
- Sits between the keypad/serial front end and the door actuator.

Parameters:
- CODE_LEN, 4, number of bits per attempt (1..16).
- CODE, 4'b0110, expected code, CODE_LEN bits wide. The first received bit is compared with the MSB.
- MAX_FAIL, 3, consecutive failures that trigger lockout (>=1).
- UNLOCK_CYCLES, 4, clock cycles that unlock stays high (>=1).
- LOCKOUT_CYCLES, 8, clock cycles spent in lockout (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- A  input  1  serial code bit.
- a_valid  input  1  A is sampled on this edge when high.
- abort  input  1  discards the partial attempt; no failure is counted.
- unlock  output  1  door-open pulse, UNLOCK_CYCLES long.
- locked_out  output  1  high throughout lockout.
- busy  output  1  high in CHECK, UNLOCKED or LOCKOUT; input is ignored.
- fail_cnt  output  $clog2(MAX_FAIL+1)  current consecutive-failure count.
- bit_cnt  output  $clog2(CODE_LEN+1)  bits collected in the current attempt.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=COLLECT.
  - shift register=0, bit_cnt=0, fail_cnt=0, timer=0.
  - unlock=0, locked_out=0, busy=0.
- All outputs are registered. Nothing changes until the first rising edge after reset deasserts.
- States: COLLECT, CHECK, UNLOCKED, LOCKOUT.
- COLLECT:
  - On an edge with a_valid=1 and abort=0: shift A into the LSB of the shift register; bit_cnt+1.
  - When the accepted bit is bit number CODE_LEN, go to CHECK on that edge. bit_cnt reads CODE_LEN while in CHECK.
  - abort=1 on any edge in COLLECT: clear shift register and bit_cnt; a_valid is ignored that edge; fail_cnt unchanged.
- CHECK (exactly one cycle), then on the next edge:
  - Match: fail_cnt=0, timer=UNLOCK_CYCLES-1, unlock=1, state=UNLOCKED.
  - Mismatch with fail_cnt+1 < MAX_FAIL: fail_cnt+1, state=COLLECT.
  - Mismatch with fail_cnt+1 == MAX_FAIL: fail_cnt=MAX_FAIL, timer=LOCKOUT_CYCLES-1, locked_out=1, state=LOCKOUT.
  - In every case bit_cnt and the shift register clear.
- UNLOCKED:
  - Timer decrements each edge.
  - On the edge where timer==0: unlock=0, state=COLLECT.
  - unlock is high for exactly UNLOCK_CYCLES cycles.
- LOCKOUT:
  - Timer decrements each edge.
  - On the edge where timer==0: locked_out=0, fail_cnt=0, state=COLLECT.
- Latency: the last code bit is accepted on edge N; unlock or locked_out rises on edge N+1.
- In CHECK, UNLOCKED and LOCKOUT, a_valid, A and abort are ignored. Bits offered there are lost, not buffered.
- unlock and locked_out are never high together.
- fail_cnt saturates at MAX_FAIL and never wraps.
- Reset asserted mid-attempt, mid-unlock or mid-lockout returns immediately to the reset values. An active unlock drops without waiting for the timer.
- A correct attempt after some failures clears fail_cnt to 0.

Optional Feature:
- Macro: LOCK_MANUAL_RELOCK_EN.
- When defined:
  - Adds input port relock (1 bit).
  - relock=1 while in UNLOCKED ends the unlock on that edge: unlock=0, state=COLLECT, timer=0.
  - relock is ignored in every other state.
- When undefined: no relock port exists, and UNLOCKED always lasts exactly UNLOCK_CYCLES cycles.

Test Plan:
- Correct code: reset low 2 cycles, then feed 0,1,1,0 with a_valid=1.
  - unlock=1 for exactly 4 cycles, starting one edge after the 4th bit.
  - fail_cnt stays 0 and busy=1 throughout.
- Lockout: feed three wrong attempts (1,1,1,1 each).
  - fail_cnt steps 1, 2.
  - After the 3rd attempt: locked_out=1 for 8 cycles, fail_cnt=3.
  - Then locked_out=0, fail_cnt=0, and 0,1,1,0 unlocks.
- Abort and recover: one wrong attempt (fail_cnt=1), then 0,1 followed by abort=1.
  - bit_cnt returns to 0 and fail_cnt stays 1.
  - Next 0,1,1,0 unlocks and clears fail_cnt to 0.
- Ignored input: while unlock=1, offer a_valid=1 bits 0,1,1,0.
  - bit_cnt stays 0 and no second unlock occurs.
- Gapped input: a_valid deasserted between bits (0, gap 3 cycles, 1, 1, gap, 0).
  - Still unlocks, and bit_cnt tracks only the valid bits.
- Async reset: assert reset=0 mid-lockout (timer=4) and mid-unlock.
  - locked_out, unlock and fail_cnt go to 0 without a clock edge.
  - With LOCK_MANUAL_RELOCK_EN defined, relock=1 on the 2nd unlock cycle ends unlock after 2 cycles.
